// File: rtl/sync_ram_pkg.sv
// Shared types and address helpers for the sync_ram initiator (sync_ram_master).
package sync_ram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BEAT = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        RD_HOLD = 3'd4
    } ram_master_state_t;

    // Modulo-m increment that never yields a value >= m, including for non-power-of-two depths.
    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned m);
        return (addr + 1 >= m) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/sync_ram_master.sv
// Burst read/write initiator for sync_ram: command handshake in, RAM port out, read beats back.
// Optional write read-back check is enabled by defining SYNC_RAM_MASTER_VERIFY_EN (adds verify_err).
module sync_ram_master
    import sync_ram_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int M      = 32,
    parameter  int LEN_W  = 3,
    localparam int AddrSz = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AddrSz-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    input  logic [N-1:0]      wd_data,
    output logic              wd_ready,
    output logic              rd_valid,
    output logic [N-1:0]      rd_data,
    input  logic              rd_ready,
    output logic              busy,
    output logic [AddrSz-1:0] addr,
    output logic [N-1:0]      w_data,
    output logic              w_en,
    input  logic [N-1:0]      r_data
`ifdef SYNC_RAM_MASTER_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    localparam int unsigned MU = M;

    ram_master_state_t state_q, state_d;
    logic [AddrSz-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              w_en_q, w_en_d;
    logic [N-1:0]      w_data_q, w_data_d;
    logic [N-1:0]      rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

`ifdef SYNC_RAM_MASTER_VERIFY_EN
    logic vrfy_q, vrfy_d;
    logic chk_q, chk_d;
    logic err_q, err_d;
`endif

    logic              cmd_fire;
    logic              wd_fire;
    logic              rd_fire;
    logic              last_beat;
    logic [AddrSz-1:0] addr_inc;
    logic [AddrSz-1:0] cmd_addr_mod;

    assign cmd_fire     = (state_q == IDLE) && cmd_valid;
    assign wd_fire      = (state_q == WR_BEAT) && wd_valid;
    assign rd_fire      = (state_q == RD_HOLD) && rd_ready;
    assign last_beat    = (rem_q == '0);
    assign addr_inc     = AddrSz'(wrap_inc(32'(addr_q), MU));
    assign cmd_addr_mod = AddrSz'(32'(cmd_addr) % MU);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = cmd_we ? WR_BEAT : RD_ADDR;
                end
            end
            WR_BEAT: begin
                if (wd_fire) begin
`ifdef SYNC_RAM_MASTER_VERIFY_EN
                    state_d = RD_ADDR;
`else
                    state_d = last_beat ? IDLE : WR_BEAT;
`endif
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
`ifdef SYNC_RAM_MASTER_VERIFY_EN
                if (vrfy_q) begin
                    state_d = last_beat ? IDLE : WR_BEAT;
                end else begin
                    state_d = RD_HOLD;
                end
`else
                state_d = RD_HOLD;
`endif
            end
            RD_HOLD: begin
                if (rd_fire) begin
                    state_d = last_beat ? IDLE : RD_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        w_en_d     = 1'b0;
        w_data_d   = w_data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
`ifdef SYNC_RAM_MASTER_VERIFY_EN
        // Write lands during RD_ADDR, RAM returns it after RD_WAIT, compare runs the cycle after.
        vrfy_d = vrfy_q;
        chk_d  = 1'b0;
        err_d  = err_q | (chk_q && (r_data != w_data_q));
`else
        // Address stays on the write beat while w_en is out, then steps past it.
        if (w_en_q) begin
            addr_d = addr_inc;
        end
`endif
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d = cmd_addr_mod;
                    rem_d  = cmd_len;
`ifdef SYNC_RAM_MASTER_VERIFY_EN
                    vrfy_d = cmd_we;
`endif
                end
            end
            WR_BEAT: begin
                if (wd_fire) begin
                    w_en_d   = 1'b1;
                    w_data_d = wd_data;
`ifndef SYNC_RAM_MASTER_VERIFY_EN
                    if (!last_beat) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
`endif
                end
            end
            RD_WAIT: begin
`ifdef SYNC_RAM_MASTER_VERIFY_EN
                if (vrfy_q) begin
                    chk_d  = 1'b1;
                    addr_d = addr_inc;
                    if (!last_beat) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end else begin
                    rd_data_d  = r_data;
                    rd_valid_d = 1'b1;
                end
`else
                rd_data_d  = r_data;
                rd_valid_d = 1'b1;
`endif
            end
            RD_HOLD: begin
                if (rd_fire) begin
                    rd_valid_d = 1'b0;
                    if (!last_beat) begin
                        addr_d = addr_inc;
                        rem_d  = rem_q - LEN_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            addr_q     <= '0;
            rem_q      <= '0;
            w_en_q     <= 1'b0;
            w_data_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef SYNC_RAM_MASTER_VERIFY_EN
            vrfy_q     <= 1'b0;
            chk_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            w_en_q     <= w_en_d;
            w_data_q   <= w_data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef SYNC_RAM_MASTER_VERIFY_EN
            vrfy_q     <= vrfy_d;
            chk_q      <= chk_d;
            err_q      <= err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wd_ready  = (state_q == WR_BEAT);
    assign busy      = (state_q != IDLE);
    assign addr      = addr_q;
    assign w_en      = w_en_q;
    assign w_data    = w_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
`ifdef SYNC_RAM_MASTER_VERIFY_EN
    assign verify_err = err_q;
`endif

endmodule

// File: tb/tb_sync_ram_master.sv
// Self-checking bench for sync_ram_master with a behavioural RAM and a word-level memory model.
module tb_sync_ram_master;

    localparam int N     = 8;
    localparam int M     = 32;
    localparam int LEN_W = 3;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic          wd_valid, wd_ready;
    logic [N-1:0]  wd_data;
    logic          rd_valid, rd_ready;
    logic [N-1:0]  rd_data;
    logic          busy;
    logic [AW-1:0] addr;
    logic [N-1:0]  w_data;
    logic          w_en;
    logic [N-1:0]  r_data;
`ifdef SYNC_RAM_MASTER_VERIFY_EN
    logic          verify_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] mem     [M];
    logic [N-1:0] ref_mem [M];
    logic [N-1:0] bufd    [8];
    logic         corrupt = 1'b0;

    typedef struct {
        bit            we;
        int            a;
        int            len;
        int            stall;
        int            bp;
        bit [3:0][7:0] d;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    sync_ram_master #(.N(N), .M(M), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_data   (wd_data),
        .wd_ready  (wd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .addr      (addr),
        .w_data    (w_data),
        .w_en      (w_en),
        .r_data    (r_data)
`ifdef SYNC_RAM_MASTER_VERIFY_EN
        ,
        .verify_err(verify_err)
`endif
    );

    // RAM: write on w_en, registered read of the presented address.
    always @(posedge clk) begin
        if (w_en) mem[addr] <= w_data;
        r_data <= mem[addr] ^ (corrupt ? 8'hFF : 8'h00);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input bit we, input int a, input int len);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = AW'(a);
        cmd_len   = LEN_W'(len);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input int a, input int len, input int stall_at, input int stall);
        int n;
        issue(1'b1, a, len);
        for (int i = 0; i <= len; i++) begin
            if (i == stall_at && stall > 0) begin
                wd_valid = 1'b0;
                n = 0;
                while (!wd_ready && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                repeat (stall) begin
                    @(negedge clk);
                    check("stall_w_en", int'(w_en), 0);
                    check("stall_addr", int'(addr), (a + i) % M);
                end
            end
            wd_valid = 1'b1;
            wd_data  = bufd[i];
            n = 0;
            while (!wd_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("wd_ready_wait", int'(wd_ready), 1);
            @(posedge clk);
            @(negedge clk);
            check("wr_w_en", int'(w_en), 1);
            check("wr_addr", int'(addr), (a + i) % M);
            check("wr_w_data", int'(w_data), int'(bufd[i]));
            ref_mem[(a + i) % M] = bufd[i];
            wd_valid = 1'b0;
        end
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_done_busy", int'(busy), 0);
    endtask

    task automatic wait_rd(output int lat);
        lat = 1;
        while (!rd_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic read_burst(input int a, input int len, input int bp);
        int lat;
        issue(1'b0, a, len);
        for (int i = 0; i <= len; i++) begin
            wait_rd(lat);
            check("rd_latency", lat, 3);
            check("rd_data", int'(rd_data), int'(bufd[i]));
            check("rd_addr", int'(addr), (a + i) % M);
            rd_ready = 1'b0;
            repeat (bp) begin
                @(negedge clk);
                check("bp_rd_valid", int'(rd_valid), 1);
                check("bp_rd_data", int'(rd_data), int'(bufd[i]));
                check("bp_addr", int'(addr), (a + i) % M);
            end
            rd_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rd_ready = 1'b0;
            check("rd_valid_fall", int'(rd_valid), 0);
        end
        check("rd_done_busy", int'(busy), 0);
    endtask

    initial begin
        int lat;
        int we, a, len, stall, stall_at, bp;

        tbl[0] = '{1'b1, 12, 0, 0, 0, {8'd0,  8'd0,  8'd0,  8'd136}};
        tbl[1] = '{1'b0, 12, 0, 0, 0, {8'd0,  8'd0,  8'd0,  8'd136}};
        tbl[2] = '{1'b1, 30, 3, 0, 0, {8'd4,  8'd3,  8'd2,  8'd1}};
        tbl[3] = '{1'b0, 30, 3, 0, 0, {8'd4,  8'd3,  8'd2,  8'd1}};
        tbl[4] = '{1'b1, 5,  3, 4, 0, {8'd40, 8'd30, 8'd20, 8'd10}};
        tbl[5] = '{1'b0, 5,  3, 0, 1, {8'd40, 8'd30, 8'd20, 8'd10}};
        tbl[6] = '{1'b0, 30, 1, 0, 5, {8'd0,  8'd0,  8'd2,  8'd1}};
        tbl[7] = '{1'b0, 31, 1, 0, 0, {8'd0,  8'd0,  8'd3,  8'd2}};

        n_reset   = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        rd_ready  = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_wd_ready", int'(wd_ready), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_w_en", int'(w_en), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_w_data", int'(w_data), 0);
        check("rst_rd_data", int'(rd_data), 0);
        n_reset = 1'b1;
        @(negedge clk);

        // Give every RAM word a known value before any read.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) bufd[i] = 8'($urandom);
            write_burst(b * 8, 7, 0, 0);
        end

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) bufd[i] = tbl[k].d[i];
            if (tbl[k].we) write_burst(tbl[k].a, tbl[k].len, 2, tbl[k].stall);
            else           read_burst(tbl[k].a, tbl[k].len, tbl[k].bp);
        end

        wd_valid = 1'b1;
        wd_data  = 8'd99;
        check("idle_wd_ready", int'(wd_ready), 0);
        @(negedge clk);
        check("idle_wd_w_en", int'(w_en), 0);
        check("idle_wd_busy", int'(busy), 0);
        wd_valid = 1'b0;

        // New command held during the final read handshake must wait one cycle.
        issue(1'b0, 12, 0);
        wait_rd(lat);
        check("simul_first_lat", lat, 3);
        check("simul_first_data", int'(rd_data), int'(ref_mem[12]));
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = AW'(30);
        cmd_len   = '0;
        rd_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_ready = 1'b0;
        check("simul_cmd_ready", int'(cmd_ready), 1);
        check("simul_busy", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("simul_accept_busy", int'(busy), 1);
        wait_rd(lat);
        check("simul_second_lat", lat, 3);
        check("simul_second_data", int'(rd_data), int'(ref_mem[30]));
        rd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_ready = 1'b0;

        issue(1'b0, 5, 3);
        wait_rd(lat);
        check("rst_mid_lat", lat, 3);
        n_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rd_valid", int'(rd_valid), 0);
        check("rst_mid_cmd_ready", int'(cmd_ready), 1);
        check("rst_mid_addr", int'(addr), 0);
        check("rst_mid_rd_data", int'(rd_data), 0);
        n_reset = 1'b1;
        @(negedge clk);
        check("rst_mid_abandoned", int'(busy), 0);

        for (int t = 0; t < 25; t++) begin
            we  = int'($urandom_range(0, 1));
            a   = int'($urandom_range(0, M - 1));
            len = int'($urandom_range(0, 7));
            if (we != 0) begin
                for (int i = 0; i < 8; i++) bufd[i] = 8'($urandom);
                stall    = int'($urandom_range(0, 3));
                stall_at = int'($urandom_range(0, len));
                write_burst(a, len, stall_at, stall);
            end else begin
                for (int i = 0; i < 8; i++) bufd[i] = ref_mem[(a + i) % M];
                bp = int'($urandom_range(0, 2));
                read_burst(a, len, bp);
            end
        end

`ifdef SYNC_RAM_MASTER_VERIFY_EN
        bufd[0] = 8'd136;
        write_burst(2, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("verify_clean", int'(verify_err), 0);
        corrupt = 1'b1;
        bufd[0] = 8'd7;
        write_burst(3, 0, 0, 0);
        repeat (3) @(negedge clk);
        corrupt = 1'b0;
        check("verify_set", int'(verify_err), 1);
        repeat (5) @(negedge clk);
        check("verify_sticky", int'(verify_err), 1);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        check("verify_cleared", int'(verify_err), 0);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
